// File: rtl/time_counter.sv
// BCD time-of-day counter: CLK_FREQ prescaler to a 1 Hz TICK, six BCD digits, hour/minute set pulses.
// Optional macro CLOCK_12H_EN selects 12-hour mode (01..12 with PM flag); default is 24-hour 00..23.
module time_counter #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       SET_H,
    input  logic       SET_M,
    output logic       TICK,
    output logic [3:0] SEC_L,
    output logic [3:0] SEC_H,
    output logic [3:0] MIN_L,
    output logic [3:0] MIN_H,
    output logic [3:0] HOUR_L,
`ifdef CLOCK_12H_EN
    output logic [3:0] HOUR_H,
    output logic       PM
`else
    output logic [3:0] HOUR_H
`endif
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PS_TC = PW'(CLK_FREQ - 1);

    logic [PW-1:0] ps_reg;
    logic          ps_tc;
    logic          sec_wrap;
    logic          min_wrap;
    logic          min_inc;
    logic          hour_inc;

    assign ps_tc    = EN && (ps_reg == PS_TC);
    assign sec_wrap = (SEC_H == 4'd5) && (SEC_L == 4'd9);
    assign min_wrap = (MIN_H == 4'd5) && (MIN_L == 4'd9);
    // Only a tick-driven wrap carries onward; set-driven wraps stay inside their field.
    assign min_inc  = (ps_tc && sec_wrap) || SET_M;
    assign hour_inc = (ps_tc && sec_wrap && min_wrap) || SET_H;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ps_reg <= '0;
            TICK   <= 1'b0;
            SEC_L  <= 4'd0;
            SEC_H  <= 4'd0;
            MIN_L  <= 4'd0;
            MIN_H  <= 4'd0;
`ifdef CLOCK_12H_EN
            HOUR_L <= 4'd2;
            HOUR_H <= 4'd1;
            PM     <= 1'b0;
`else
            HOUR_L <= 4'd0;
            HOUR_H <= 4'd0;
`endif
        end else begin
            TICK <= ps_tc;
            if (ps_tc)
                ps_reg <= '0;
            else if (EN)
                ps_reg <= ps_reg + PW'(1);

            if (ps_tc) begin
                if (SEC_L == 4'd9) begin
                    SEC_L <= 4'd0;
                    SEC_H <= (SEC_H == 4'd5) ? 4'd0 : SEC_H + 4'd1;
                end else begin
                    SEC_L <= SEC_L + 4'd1;
                end
            end

            if (min_inc) begin
                if (MIN_L == 4'd9) begin
                    MIN_L <= 4'd0;
                    MIN_H <= min_wrap ? 4'd0 : MIN_H + 4'd1;
                end else begin
                    MIN_L <= MIN_L + 4'd1;
                end
            end

            if (hour_inc) begin
`ifdef CLOCK_12H_EN
                // 12 -> 01 keeps PM; 11 -> 12 crosses noon/midnight and flips it.
                if (HOUR_H == 4'd1 && HOUR_L == 4'd2) begin
                    HOUR_H <= 4'd0;
                    HOUR_L <= 4'd1;
                end else if (HOUR_H == 4'd1 && HOUR_L == 4'd1) begin
                    HOUR_L <= 4'd2;
                    PM     <= ~PM;
                end else if (HOUR_L == 4'd9) begin
                    HOUR_L <= 4'd0;
                    HOUR_H <= HOUR_H + 4'd1;
                end else begin
                    HOUR_L <= HOUR_L + 4'd1;
                end
`else
                if (HOUR_H == 4'd2 && HOUR_L == 4'd3) begin
                    HOUR_H <= 4'd0;
                    HOUR_L <= 4'd0;
                end else if (HOUR_L == 4'd9) begin
                    HOUR_L <= 4'd0;
                    HOUR_H <= HOUR_H + 4'd1;
                end else begin
                    HOUR_L <= HOUR_L + 4'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Randomized scoreboard bench for time_counter: an integer-arithmetic clock model predicts
// every cycle's outputs; a monitor on the falling edge compares them against the DUT.
module tb_time_counter;

    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       set_h = 1'b0;
    logic       set_m = 1'b0;
    logic       tick;
    logic [3:0] sec_l, sec_h, min_l, min_h, hour_l, hour_h;
    logic       pm_act;

    always #5 clk = ~clk;

`ifdef CLOCK_12H_EN
    logic pm;
    assign pm_act = pm;
    localparam bit MODE12 = 1'b1;
`else
    assign pm_act = 1'b0;
    localparam bit MODE12 = 1'b0;
`endif

    time_counter #(.CLK_FREQ(F)) dut (
        .CLK   (clk),
        .RST   (rst),
        .EN    (en),
        .SET_H (set_h),
        .SET_M (set_m),
        .TICK  (tick),
        .SEC_L (sec_l),
        .SEC_H (sec_h),
        .MIN_L (min_l),
        .MIN_H (min_h),
        .HOUR_L(hour_l),
`ifdef CLOCK_12H_EN
        .HOUR_H(hour_h),
        .PM    (pm)
`else
        .HOUR_H(hour_h)
`endif
    );

    // Reference model: whole-number hours/minutes/seconds and an integer prescaler count.
    int m_h = 0, m_m = 0, m_s = 0, m_pc = 0;
    bit m_pm = 0, m_tick = 0;

    logic [25:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [25:0] pack_model();
        return {m_pm, m_tick, 4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
                4'(m_s / 10), 4'(m_s % 10)};
    endfunction

    function automatic void model_update(input bit r, input bit e, input bit sh, input bit sm);
        bit carry_s, carry_m;
        if (r) begin
            m_s = 0; m_m = 0; m_pc = 0; m_tick = 0; m_pm = 0;
            m_h = MODE12 ? 12 : 0;
            return;
        end
        m_tick  = e && (m_pc == F - 1);
        m_pc    = m_tick ? 0 : (e ? m_pc + 1 : m_pc);
        carry_s = m_tick && (m_s == 59);
        carry_m = carry_s && (m_m == 59);
        if (m_tick) m_s = (m_s + 1) % 60;
        if (carry_s || sm) m_m = (m_m + 1) % 60;
        if (carry_m || sh) begin
            if (MODE12) begin
                if (m_h == 11) m_pm = !m_pm;
                m_h = (m_h % 12) + 1;
            end else begin
                m_h = (m_h + 1) % 24;
            end
        end
    endfunction

    task automatic step(input bit r, input bit e, input bit sh, input bit sm);
        rst = r; en = e; set_h = sh; set_m = sm;
        model_update(r, e, sh, sm);
        exp_q.push_back(pack_model());
        @(posedge clk);
        #1;
    endtask

    task automatic goto_time(input int th, input int tm, input int ts);
        step(1, 0, 0, 0);
        for (int i = 0; i < 30 && m_h != th; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 70 && m_m != tm; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 70 * F && m_s != ts; i++) step(0, 1, 0, 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    // Monitor: every registered cycle is a DUT output to check.
    initial begin
        logic [25:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pm_act, tick, hour_h, hour_l, min_h, min_l, sec_h, sec_l};
                vectors++;
                if (act_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL vec%0d time: got %h%h:%h%h:%h%h pm=%b tick=%b, expected %h%h:%h%h:%h%h pm=%b tick=%b",
                             vectors, act_v[23:20], act_v[19:16], act_v[15:12], act_v[11:8],
                             act_v[7:4], act_v[3:0], act_v[25], act_v[24],
                             exp_v[23:20], exp_v[19:16], exp_v[15:12], exp_v[11:8],
                             exp_v[7:4], exp_v[3:0], exp_v[25], exp_v[24]);
                end else if (act_v[24]) begin
                    $display("vec%0d tick -> %h%h:%h%h:%h%h pm=%b", vectors, act_v[23:20],
                             act_v[19:16], act_v[15:12], act_v[11:8], act_v[7:4], act_v[3:0],
                             act_v[25]);
                end
            end
        end
    end

    initial begin
        // Reset, then free-running prescaler.
        step(1, 1, 0, 0);
        run(13);

        // Full wrap of every field on a single tick.
        goto_time(MODE12 ? 11 : 23, 59, 58);
        run(2 * F);

        // Tick carry into minutes collides with SET_M: minutes advance only once.
        goto_time(12, 34, 59);
        for (int i = 0; i < F && m_pc != F - 1; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        run(2);

        // Set-driven wraps generate no carry.
        goto_time(MODE12 ? 12 : 23, 59, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);

        // EN low freezes the prescaler; set pulses still honoured while frozen.
        run(2);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        run(2 * F);

        // Reset beats simultaneous set pulses.
        step(1, 1, 1, 1);
        run(2);

        // Noon and 12 -> 1 transitions (plain hour carries in 24-hour mode).
        goto_time(11, 59, 59);
        run(F + 1);
        goto_time(12, 59, 59);
        run(F + 1);

        // Randomized traffic, including held set inputs and occasional resets.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 500) == 0, ($urandom % 4) != 0,
                 ($urandom % 12) == 0, ($urandom % 6) == 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);

        rst = 1'b0; en = 1'b0; set_h = 1'b0; set_m = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
